fft_pingpong_ram: RTL

FFT_PINGPONG_RAM -- requirements
Module: fft_pingpong_ram

---
 rtl/fft_pingpong_ram_if.sv | 37 +++
 rtl/fft_pingpong_ram.sv | 107 ++++++++++
 2 files changed

// File: rtl/fft_pingpong_ram_if.sv
// Purpose: bundle of load-side and compute-side signals for the FFT ping-pong RAM.
// Latency: n/a (wiring only); q_a/q_b are registered inside the RAM, one cycle after address.
// Backpressure: in_ready drops while the load bank holds a full frame that cannot be swapped yet.
// Ports: master = FFT engine / sample source side, slave = the RAM itself.
interface fft_pingpong_ram_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 6
);
    // load side
    logic              in_valid;
    logic [WIDTH-1:0]  in_data;
    logic              in_ready;
    // compute side
    logic              comp_write;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [WIDTH-1:0]  d_a;
    logic [WIDTH-1:0]  d_b;
    logic [WIDTH-1:0]  q_a;
    logic [WIDTH-1:0]  q_b;
    logic              comp_done;
    logic              comp_start;
    logic              comp_busy;
    // status
    logic              bank_sel;
    logic [ADDR_W:0]   load_count;

    modport master (
        output in_valid, in_data, comp_write, addr_a, addr_b, d_a, d_b, comp_done,
        input  in_ready, q_a, q_b, comp_start, comp_busy, bank_sel, load_count
    );

    modport slave (
        input  in_valid, in_data, comp_write, addr_a, addr_b, d_a, d_b, comp_done,
        output in_ready, q_a, q_b, comp_start, comp_busy, bank_sel, load_count
    );
endinterface

// File: rtl/fft_pingpong_ram.sv
// Purpose: two-bank ping-pong sample RAM; one bank loads a frame, the other serves the FFT engine.
// Latency: load write same edge as accept; compute reads registered, data one cycle after address.
// Backpressure: in_ready low once N samples are loaded until the frame can swap into compute.
// Ports: clk, reset (sync, active-high), bus (slave modport): in_valid/in_data/in_ready load stream,
//        comp_write/addr_a/addr_b/d_a/d_b/q_a/q_b dual-port compute access,
//        comp_done in, comp_start/comp_busy out, bank_sel and load_count status.
module fft_pingpong_ram #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 6,
    parameter bit BITREV = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    fft_pingpong_ram_if.slave     bus
);
    localparam int N = 1 << ADDR_W;

    // Both banks live in one array; the bank index is the address MSB.
    logic [WIDTH-1:0]  mem [0:2*N-1];

    logic              bank_sel_r;
    logic [ADDR_W:0]   load_cnt;
    logic              busy;
    logic              start;
    logic [WIDTH-1:0]  q_a_r;
    logic [WIDTH-1:0]  q_b_r;

    logic              load_full;
    logic              accept;
    logic              swap;
    logic              cwr;
    logic [ADDR_W-1:0] load_addr;

    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = a[ADDR_W-1-i];
        end
        return r;
    endfunction

    always_comb begin
        // The count's MSB is set exactly when it reaches N.
        load_full = load_cnt[ADDR_W];
        accept    = bus.in_valid && !load_full && !reset;
        // A full frame moves into compute as soon as the engine is idle or
        // releasing its bank this very cycle, so busy never dips low.
        swap      = load_full && (!busy || bus.comp_done);
        cwr       = bus.comp_write && busy && !reset;
        load_addr = BITREV ? bitrev(load_cnt[ADDR_W-1:0]) : load_cnt[ADDR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_sel_r <= 1'b0;
            load_cnt   <= '0;
            busy       <= 1'b0;
            start      <= 1'b0;
        end else begin
            start <= swap;
            if (swap) begin
                bank_sel_r <= ~bank_sel_r;
                load_cnt   <= '0;
                busy       <= 1'b1;
            end else begin
                if (accept) begin
                    load_cnt <= load_cnt + 1'b1;
                end
                if (bus.comp_done && busy) begin
                    busy <= 1'b0;
                end
            end
        end
    end

    // Memory is never cleared; reset only blocks writes in its cycle.
    // Port A is written last so it wins when both compute addresses collide.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[{bank_sel_r, load_addr}] <= bus.in_data;
        end
        if (cwr) begin
            mem[{~bank_sel_r, bus.addr_b}] <= bus.d_b;
            mem[{~bank_sel_r, bus.addr_a}] <= bus.d_a;
        end
    end

    // Read-before-write: non-blocking reads return the pre-edge contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_a_r <= '0;
            q_b_r <= '0;
        end else begin
            q_a_r <= mem[{~bank_sel_r, bus.addr_a}];
            q_b_r <= mem[{~bank_sel_r, bus.addr_b}];
        end
    end

    assign bus.in_ready   = !load_full;
    assign bus.comp_start = start;
    assign bus.comp_busy  = busy;
    assign bus.bank_sel   = bank_sel_r;
    assign bus.load_count = load_cnt;
    assign bus.q_a        = q_a_r;
    assign bus.q_b        = q_b_r;
endmodule
